layer_color_mapper: RTL and testbench

Pipelined, parametrised palette compositor that sits between the sprite/background ROM readers and the VGA DAC outputs. Each pixel it resolves NUM_LAYERS sprite layers plus one background index by fixed priority and treats index 0 as transparent. It looks the winner up in a run-time writable 24-bit palette RAM, then scales the colour by a global brightness level driven by a frame-synchronous fade state machine (screen fade-out/fade-in between levels).

---
 rtl/layer_color_mapper.sv | 153 +++++++++++++++
 tb/tb_layer_color_mapper.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/layer_color_mapper.sv
// Palette compositor: priority layer select, palette RAM lookup and brightness
// scaling in a 3-stage pipeline, with a frame-synchronous fade controller.
//
// state    | meaning
// IDLE     | full brightness, level 256
// FADE_OUT | level drops by FADE_STEP per frame_tick
// DARK     | blanked, level 0
// FADE_IN  | level rises by FADE_STEP per frame_tick
module layer_color_mapper #(
  parameter int NUM_LAYERS = 2,
  parameter int IDX_W      = 6,
  parameter int PAL_DEPTH  = 64,
  parameter int FADE_STEP  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_valid_in,
  input  logic [NUM_LAYERS-1:0]   layer_hit,
  input  logic [8*NUM_LAYERS-1:0] layer_idx,
  input  logic [7:0]              bg_idx,
  input  logic                    pal_we,
  input  logic [IDX_W-1:0]        pal_waddr,
  input  logic [23:0]             pal_wdata,
  input  logic                    frame_tick,
  input  logic                    fade_start,
  input  logic                    fade_dir,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    pix_valid_out,
  output logic                    fade_busy,
  output logic [8:0]              fade_level
);

  typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} fade_state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(PAL_DEPTH);
  localparam logic [8:0]     STEP_L  = 9'(FADE_STEP);
  localparam logic [8:0]     IN_LIM  = 9'(256 - FADE_STEP);
  localparam logic [8:0]     FULL    = 9'd256;

  fade_state_t      state, state_n;
  logic [8:0]       level_n;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  logic             unused_hi;

  logic             s1_valid, s2_valid;
  logic [IDX_W-1:0] sel_idx;
  logic [23:0]      rd_rgb;
  logic [23:0]      pal_mem [PAL_DEPTH];

  // S1: first hit layer with a non-transparent index wins, else background
  always_comb begin
    win_idx = bg_idx[IDX_W-1:0];
    found   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_hit[i] && (layer_idx[8*i +: IDX_W] != '0)) begin
        win_idx = layer_idx[8*i +: IDX_W];
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    unused_hi = ^bg_idx[7:IDX_W];
    for (int i = 0; i < NUM_LAYERS; i++)
      unused_hi = unused_hi ^ (^layer_idx[8*i+IDX_W +: 8-IDX_W]);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      sel_idx  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= pix_valid_in;
      sel_idx  <= win_idx;
      s2_valid <= s1_valid;
    end
  end

  // Palette RAM has no reset; read returns pre-write data on address collision
  always_ff @(posedge Clk) begin
    if (Reset_n && pal_we && ({1'b0, pal_waddr} < DEPTH_L))
      pal_mem[pal_waddr] <= pal_wdata;
    if ({1'b0, sel_idx} < DEPTH_L)
      rd_rgb <= pal_mem[sel_idx];
    else
      rd_rgb <= 24'h000000;
  end

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] lvl);
    return 8'(({9'b0, c} * {8'b0, lvl}) >> 8);
  endfunction

  // S3: invalid pixels leave as black
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      VGA_R         <= 8'h00;
      VGA_G         <= 8'h00;
      VGA_B         <= 8'h00;
      pix_valid_out <= 1'b0;
    end else begin
      VGA_R         <= s2_valid ? scale(rd_rgb[23:16], fade_level) : 8'h00;
      VGA_G         <= s2_valid ? scale(rd_rgb[15:8],  fade_level) : 8'h00;
      VGA_B         <= s2_valid ? scale(rd_rgb[7:0],   fade_level) : 8'h00;
      pix_valid_out <= s2_valid;
    end
  end

  // A fade command wins over a coincident frame_tick; the level is never reset by a restart
  always_comb begin
    state_n = state;
    level_n = fade_level;
    if (fade_start) begin
      state_n = fade_dir ? FADE_IN : FADE_OUT;
    end else if (frame_tick) begin
      case (state)
        FADE_OUT: begin
          if (fade_level > STEP_L) begin
            level_n = fade_level - STEP_L;
          end else begin
            level_n = '0;
            state_n = DARK;
          end
        end
        FADE_IN: begin
          if (fade_level < IN_LIM) begin
            level_n = fade_level + STEP_L;
          end else begin
            level_n = FULL;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      fade_level <= FULL;
      fade_busy  <= 1'b0;
    end else begin
      state      <= state_n;
      fade_level <= level_n;
      fade_busy  <= (state_n == FADE_OUT) || (state_n == FADE_IN);
    end
  end

endmodule

// File: tb/tb_layer_color_mapper.sv
// Directed bench for layer_color_mapper: priority, palette collisions, range
// limits, fade sequencing and reset behaviour, with hand-computed expectations.
module tb_layer_color_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid_in;
  logic [1:0]  layer_hit;
  logic [15:0] layer_idx;
  logic [7:0]  bg_idx;
  logic        pal_we;
  logic [5:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic        frame_tick;
  logic        fade_start;
  logic        fade_dir;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        pix_valid_out;
  logic        fade_busy;
  logic [8:0]  fade_level;

  int n_tests = 0;
  int n_fail  = 0;

  layer_color_mapper #(
    .NUM_LAYERS(2), .IDX_W(6), .PAL_DEPTH(48), .FADE_STEP(16)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in),
    .layer_hit(layer_hit), .layer_idx(layer_idx), .bg_idx(bg_idx),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid_out(pix_valid_out), .fade_busy(fade_busy), .fade_level(fade_level)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pal_write(input logic [5:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
    step();
    pal_we = 1'b0;
  endtask

  task automatic pix_check(input string tag, input logic v, input logic [1:0] hit,
                           input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] bg, input logic [23:0] exp);
    pix_valid_in = v; layer_hit = hit; layer_idx = {l1, l0}; bg_idx = bg;
    step();
    pix_valid_in = 1'b0; layer_hit = 2'b00;
    step();
    chk({tag, "_early"}, {31'b0, pix_valid_out}, 32'd0);
    step();
    chk(tag, {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, exp});
    chk({tag, "_pv"}, {31'b0, pix_valid_out}, {31'b0, v});
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic start(input logic dir);
    fade_start = 1'b1; fade_dir = dir;
    step();
    fade_start = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; pix_valid_in = 1'b0; layer_hit = 2'b00; layer_idx = 16'h0;
    bg_idx = 8'h0; pal_we = 1'b0; pal_waddr = 6'd0; pal_wdata = 24'h0;
    frame_tick = 1'b0; fade_start = 1'b0; fade_dir = 1'b0;
    step(); step();
    chk("rst_rgb",   {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_pv",    {31'b0, pix_valid_out}, 32'd0);
    chk("rst_level", {23'b0, fade_level}, 32'd256);
    chk("rst_busy",  {31'b0, fade_busy}, 32'd0);
    Reset_n = 1'b1;
    step();

    pal_write(6'd0,  24'h0A0B0C);
    pal_write(6'd3,  24'h0C0C0C);
    pal_write(6'd5,  24'h112233);
    pal_write(6'd7,  24'hFF8001);
    pal_write(6'd9,  24'hABCDEF);
    pal_write(6'd47, 24'h474747);

    pix_check("prio_l0_transp", 1'b1, 2'b11, 8'd0,  8'd5, 8'd3, 24'h112233);
    pix_check("prio_l0_wins",   1'b1, 2'b11, 8'd7,  8'd5, 8'd3, 24'hFF8001);
    pix_check("bg_zero",        1'b1, 2'b00, 8'd7,  8'd5, 8'd0, 24'h0A0B0C);
    pix_check("l0_not_hit",     1'b1, 2'b10, 8'd7,  8'd5, 8'd3, 24'h112233);
    pix_check("idx_hi_masked",  1'b1, 2'b11, 8'h40, 8'd5, 8'd3, 24'h112233);
    pix_check("bg_last_entry",  1'b1, 2'b00, 8'd0,  8'd0, 8'd47, 24'h474747);
    pix_check("bg_out_range",   1'b1, 2'b00, 8'd0,  8'd0, 8'd50, 24'h000000);
    pix_check("invalid_black",  1'b0, 2'b11, 8'd7,  8'd5, 8'd7, 24'h000000);

    pal_write(6'd50, 24'hFFFFFF);
    pix_check("oor_write_50",   1'b1, 2'b00, 8'd0, 8'd0, 8'd50, 24'h000000);
    pix_check("oor_write_47",   1'b1, 2'b00, 8'd0, 8'd0, 8'd47, 24'h474747);

    // write to address 9 in the same cycle the first pixel reads it
    pix_valid_in = 1'b1; layer_hit = 2'b00; bg_idx = 8'd9;
    step();
    pal_we = 1'b1; pal_waddr = 6'd9; pal_wdata = 24'h123456;
    step();
    pal_we = 1'b0; pix_valid_in = 1'b0;
    step();
    chk("coll_old",    {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00ABCDEF);
    chk("coll_old_pv", {31'b0, pix_valid_out}, 32'd1);
    step();
    chk("coll_new",    {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00123456);
    step();

    start(1'b0);
    chk("fo_busy0",  {31'b0, fade_busy}, 32'd1);
    chk("fo_level0", {23'b0, fade_level}, 32'd256);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fo_level", {23'b0, fade_level}, 32'(256 - 16*i));
      chk("fo_busy",  {31'b0, fade_busy}, (i < 16) ? 32'd1 : 32'd0);
      if (i == 8) pix_check("scale_128", 1'b1, 2'b00, 8'd0, 8'd0, 8'd7, 24'h7F4000);
    end
    pix_check("scale_0", 1'b1, 2'b00, 8'd0, 8'd0, 8'd7, 24'h000000);

    start(1'b0);
    chk("dark_restart_busy", {31'b0, fade_busy}, 32'd1);
    tick();
    chk("dark_exit_busy",  {31'b0, fade_busy}, 32'd0);
    chk("dark_exit_level", {23'b0, fade_level}, 32'd0);

    start(1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fi_level", {23'b0, fade_level}, 32'(16*i));
    end
    chk("fi_done_busy", {31'b0, fade_busy}, 32'd0);

    start(1'b0);
    for (int i = 1; i <= 4; i++) tick();
    chk("rev_level_192", {23'b0, fade_level}, 32'd192);
    pix_check("scale_192", 1'b1, 2'b00, 8'd0, 8'd0, 8'd7, 24'hBF6000);

    fade_start = 1'b1; fade_dir = 1'b1; frame_tick = 1'b1;
    step();
    fade_start = 1'b0; frame_tick = 1'b0;
    chk("rev_coll_level", {23'b0, fade_level}, 32'd192);
    chk("rev_coll_busy",  {31'b0, fade_busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rev_level", {23'b0, fade_level}, 32'(192 + 16*i));
      chk("rev_busy",  {31'b0, fade_busy}, (i < 4) ? 32'd1 : 32'd0);
    end

    start(1'b1);
    chk("idle_restart_busy", {31'b0, fade_busy}, 32'd1);
    tick();
    chk("idle_exit_busy",  {31'b0, fade_busy}, 32'd0);
    chk("idle_exit_level", {23'b0, fade_level}, 32'd256);

    start(1'b0);
    for (int i = 1; i <= 12; i++) tick();
    chk("pre_rst_level", {23'b0, fade_level}, 32'd64);
    chk("pre_rst_busy",  {31'b0, fade_busy}, 32'd1);
    pix_valid_in = 1'b1; bg_idx = 8'd7;
    step(); step();
    Reset_n = 1'b0; pal_we = 1'b1; pal_waddr = 6'd3; pal_wdata = 24'hDEAD00;
    step();
    chk("mid_rst_rgb",   {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("mid_rst_pv",    {31'b0, pix_valid_out}, 32'd0);
    chk("mid_rst_level", {23'b0, fade_level}, 32'd256);
    chk("mid_rst_busy",  {31'b0, fade_busy}, 32'd0);
    Reset_n = 1'b1; pal_we = 1'b0; pix_valid_in = 1'b0;
    step(); step(); step();
    chk("post_rst_flushed", {31'b0, pix_valid_out}, 32'd0);
    pix_check("rst_write_ignored", 1'b1, 2'b00, 8'd0, 8'd0, 8'd3, 24'h0C0C0C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
